forward_cfg_sequencer: RTL and testbench

Run-time configuration sequencer for the forwarding-selection muxes of one dpsram_block column. It holds a shadow and an active 8-bit forward-control word for each of NUM_SEL selectors. Host writes land in the shadow bank through a valid/ready port. A commit drives every selector to a safe all-local setting for a settle window, then applies all shadow words at once, so the up/low forwarding chain never passes through a partially updated or looped configuration.

---
 rtl/forward_cfg_pkg.sv | 28 ++
 rtl/forward_cfg_bank.sv | 51 +++++
 rtl/forward_cfg_sequencer.sv | 109 ++++++++++
 tb/tb_forward_cfg_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/forward_cfg_pkg.sv
// Shared types and constants for the forwarding-selector configuration sequencer.
// Field positions describe the 8-bit forward-control word seen by each selector.
package forward_cfg_pkg;

    localparam int CFG_W = 8;
    localparam logic [CFG_W-1:0] SAFE_CFG = 8'h00;

    // Forward-control word layout
    localparam int RAM_SRC_LSB    = 0;
    localparam int RAM_SRC_W      = 2;
    localparam int LOCAL_SEL_LSB  = 2;
    localparam int LOCAL_SEL_W    = 2;
    localparam int GLOBAL_SEL_LSB = 4;
    localparam int GLOBAL_SEL_W   = 2;
    localparam int LOW_OUT_BIT    = 6;
    localparam int UP_OUT_BIT     = 7;

    localparam int CNT_W = 8;

    typedef logic [CFG_W-1:0] cfg_word_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_QUIESCE = 2'd1,
        ST_SETTLE  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/forward_cfg_bank.sv
// Shadow/active register pair for one forwarding selector, plus the registered
// output word that is forced to the safe setting while a commit is in flight.
module forward_cfg_bank
    import forward_cfg_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      wr_en_i,
    input  cfg_word_t wr_data_i,
    input  logic      apply_i,
    input  logic      force_safe_i,
    output cfg_word_t cfg_o
);

    cfg_word_t shadow_q, shadow_d;
    cfg_word_t active_q, active_d;
    cfg_word_t out_q,    out_d;

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        out_d    = active_q;
        if (wr_en_i) begin
            shadow_d = wr_data_i;
        end
        if (apply_i) begin
            active_d = shadow_q;
            out_d    = shadow_q;
        end
        if (force_safe_i) begin
            out_d = SAFE_CFG;
        end
    end

    // NOTE: the shadow bank is plain flops, so it is reset like any other state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shadow_q <= SAFE_CFG;
            active_q <= SAFE_CFG;
            out_q    <= SAFE_CFG;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            out_q    <= out_d;
        end
    end

    assign cfg_o = out_q;

endmodule

// File: rtl/forward_cfg_sequencer.sv
// Commit sequencer for the forwarding-selection muxes of one column: host writes
// fill a shadow bank, a commit quiesces all selectors and then applies them together.
module forward_cfg_sequencer
    import forward_cfg_pkg::*;
#(
    parameter  int NUM_SEL    = 4,
    parameter  int SETTLE_CYC = 3,
    localparam int AW         = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_valid_i,
    output logic                     wr_ready_o,
    input  logic [AW-1:0]            wr_addr_i,
    input  logic [CFG_W-1:0]         wr_data_i,
    input  logic                     commit_i,
    output logic                     busy_o,
    output logic                     commit_done_o,
    output logic                     err_o,
    output logic [CFG_W*NUM_SEL-1:0] cfg_forward_ctrl_o
);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             done_q,  done_d;
    logic             err_q,   err_d;

    logic wr_accept;
    logic addr_ok;
    logic apply;
    logic force_safe;

    assign wr_accept = wr_valid_i && (state_q == ST_IDLE);
    assign addr_ok   = 32'(wr_addr_i) < 32'(NUM_SEL);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        apply   = 1'b0;
        err_d   = wr_accept && !addr_ok;

        unique case (state_q)
            ST_IDLE: begin
                if (commit_i) begin
                    state_d = ST_QUIESCE;
                end
            end
            ST_QUIESCE: begin
                if (SETTLE_CYC == 0) begin
                    state_d = ST_IDLE;
                    apply   = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_SETTLE;
                    cnt_d   = CNT_W'(SETTLE_CYC);
                end
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    apply   = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Output registers load the safe word on the same edge the sequence starts
        force_safe = (state_d != ST_IDLE);
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    for (genvar k = 0; k < NUM_SEL; k++) begin : g_sel
        forward_cfg_bank u_bank (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .wr_en_i      (wr_accept && addr_ok && (wr_addr_i == AW'(k))),
            .wr_data_i    (wr_data_i),
            .apply_i      (apply),
            .force_safe_i (force_safe),
            .cfg_o        (cfg_forward_ctrl_o[k*CFG_W +: CFG_W])
        );
    end

    assign wr_ready_o    = (state_q == ST_IDLE);
    assign busy_o        = (state_q != ST_IDLE);
    assign commit_done_o = done_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_forward_cfg_sequencer.sv
// Scoreboard bench: two sequencers (4 selectors/settle 3 and 3 selectors/settle 0)
// share one stimulus stream; a cycle-window reference model predicts their responses.
module tb_forward_cfg_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       wr_valid;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       commit;

    logic        a_ready, a_busy, a_done, a_err;
    logic [31:0] a_cfg;
    logic        b_ready, b_busy, b_done, b_err;
    logic [23:0] b_cfg;

    forward_cfg_sequencer #(.NUM_SEL(4), .SETTLE_CYC(3)) u_dut_a (
        .clk_i              (clk),
        .rst_i              (rst),
        .wr_valid_i         (wr_valid),
        .wr_ready_o         (a_ready),
        .wr_addr_i          (wr_addr),
        .wr_data_i          (wr_data),
        .commit_i           (commit),
        .busy_o             (a_busy),
        .commit_done_o      (a_done),
        .err_o              (a_err),
        .cfg_forward_ctrl_o (a_cfg)
    );

    forward_cfg_sequencer #(.NUM_SEL(3), .SETTLE_CYC(0)) u_dut_b (
        .clk_i              (clk),
        .rst_i              (rst),
        .wr_valid_i         (wr_valid),
        .wr_ready_o         (b_ready),
        .wr_addr_i          (wr_addr),
        .wr_data_i          (wr_data),
        .commit_i           (commit),
        .busy_o             (b_busy),
        .commit_done_o      (b_done),
        .err_o              (b_err),
        .cfg_forward_ctrl_o (b_cfg)
    );

    typedef struct {
        int          cyc;
        logic [31:0] cfg;
    } done_t;

    int          checks = 0;
    int          errors = 0;
    int          edge_n = 0;
    logic [7:0]  sh [2][4];
    int          idle_edge [2];
    logic [31:0] mon_active [2];
    done_t       dq0[$];
    done_t       dq1[$];
    int          eq0[$];
    int          eq1[$];

    function automatic int nsel(input int d);
        return (d == 0) ? 4 : 3;
    endfunction

    function automatic int settle(input int d);
        return (d == 0) ? 3 : 0;
    endfunction

    function automatic logic [31:0] pack(input int d);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < nsel(d); k++) w[k*8 +: 8] = sh[d][k];
        return w;
    endfunction

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cyc=%0d got=%h expected=%h", name, d, edge_n, act, exp);
        end
    endtask

    // Reference model: the sequencer is idle again S+2 edges after an accepted commit,
    // the new words appear with the done pulse S+1 edges after it.
    task automatic model_edge();
        done_t e;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                for (int k = 0; k < 4; k++) sh[d][k] = 8'h00;
                idle_edge[d]  = 0;
                mon_active[d] = 32'h0;
                if (d == 0) begin dq0.delete(); eq0.delete(); end
                else        begin dq1.delete(); eq1.delete(); end
            end else if (edge_n >= idle_edge[d]) begin
                if (wr_valid) begin
                    if (int'(wr_addr) < nsel(d)) sh[d][wr_addr] = wr_data;
                    else if (d == 0) eq0.push_back(edge_n);
                    else             eq1.push_back(edge_n);
                end
                if (commit) begin
                    idle_edge[d] = edge_n + settle(d) + 2;
                    e.cyc = edge_n + settle(d) + 1;
                    e.cfg = pack(d);
                    if (d == 0) dq0.push_back(e);
                    else        dq1.push_back(e);
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        edge_n++;
        model_edge();
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] a, input logic [7:0] dt, input logic c);
        wr_valid = v;
        wr_addr  = a;
        wr_data  = dt;
        commit   = c;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 2'd0, 8'h00, 1'b0);
    endtask

    task automatic mon_dut(input int d, input logic busy, input logic ready, input logic done,
                           input logic err, input logic [31:0] cfg);
        logic  exp_busy, exp_done, exp_err;
        done_t e;
        exp_busy = (edge_n + 1 < idle_edge[d]);
        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (d == 0) begin
            if (dq0.size() > 0 && dq0[0].cyc == edge_n) begin
                e = dq0.pop_front(); exp_done = 1'b1; mon_active[0] = e.cfg;
            end
            if (eq0.size() > 0 && eq0[0] == edge_n) begin
                void'(eq0.pop_front()); exp_err = 1'b1;
            end
        end else begin
            if (dq1.size() > 0 && dq1[0].cyc == edge_n) begin
                e = dq1.pop_front(); exp_done = 1'b1; mon_active[1] = e.cfg;
            end
            if (eq1.size() > 0 && eq1[0] == edge_n) begin
                void'(eq1.pop_front()); exp_err = 1'b1;
            end
        end
        check("busy",  d, {31'b0, busy},  {31'b0, exp_busy});
        check("ready", d, {31'b0, ready}, {31'b0, !exp_busy});
        check("done",  d, {31'b0, done},  {31'b0, exp_done});
        check("err",   d, {31'b0, err},   {31'b0, exp_err});
        check("cfg",   d, cfg, exp_busy ? 32'h0 : mon_active[d]);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (edge_n >= 1) begin
                mon_dut(0, a_busy, a_ready, a_done, a_err, a_cfg);
                mon_dut(1, b_busy, b_ready, b_done, b_err, {8'h00, b_cfg});
            end
        end
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            idle_edge[d]  = 0;
            mon_active[d] = 32'h0;
            for (int k = 0; k < 4; k++) sh[d][k] = 8'h00;
        end
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_addr  = 2'd0;
        wr_data  = 8'h00;
        commit   = 1'b0;
        repeat (3) step();
        rst = 1'b0;

        // Shadow write alone must not reach the outputs
        drive(1'b1, 2'd2, 8'hA5, 1'b0);
        idle(6);

        // Basic commit; address 3 is out of range for the 3-selector instance
        drive(1'b1, 2'd0, 8'h11, 1'b0);
        drive(1'b1, 2'd1, 8'h22, 1'b0);
        drive(1'b1, 2'd2, 8'h33, 1'b0);
        drive(1'b1, 2'd3, 8'h44, 1'b0);
        drive(1'b0, 2'd0, 8'h00, 1'b1);
        idle(8);

        // Write together with commit, then a second commit while busy
        drive(1'b1, 2'd1, 8'hC3, 1'b1);
        drive(1'b0, 2'd0, 8'h00, 1'b0);
        drive(1'b0, 2'd0, 8'h00, 1'b1);
        idle(8);

        // Write held across a busy window
        drive(1'b0, 2'd0, 8'h00, 1'b1);
        repeat (6) drive(1'b1, 2'd0, 8'h5A, 1'b0);
        drive(1'b0, 2'd0, 8'h00, 1'b1);
        idle(8);

        // Out-of-range write followed by a commit
        drive(1'b1, 2'd3, 8'hFF, 1'b0);
        drive(1'b0, 2'd0, 8'h00, 1'b1);
        idle(8);

        // Reset in the middle of the settle window
        drive(1'b1, 2'd2, 8'h77, 1'b0);
        drive(1'b0, 2'd0, 8'h00, 1'b1);
        idle(2);
        rst = 1'b1;
        drive(1'b0, 2'd0, 8'h00, 1'b0);
        rst = 1'b0;
        idle(4);

        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  8'($urandom_range(0, 255)), ($urandom_range(0, 5) == 0));
        end
        rst = 1'b0;
        idle(10);

        check("pending_done", 0, 32'(dq0.size() + eq0.size()), 32'h0);
        check("pending_done", 1, 32'(dq1.size() + eq1.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
